// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the EX stage and the multiply/divide unit
interface mul_div_unit_if #(parameter int XLEN = 32);
  logic            START;
  logic [4:0]      ALUOP;
  logic [XLEN-1:0] OPERAND1;
  logic [XLEN-1:0] OPERAND2;
  logic            FLUSH;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;
  modport master (output START, ALUOP, OPERAND1, OPERAND2, FLUSH, input BUSY, DONE, RESULT);
  modport slave  (input START, ALUOP, OPERAND1, OPERAND2, FLUSH, output BUSY, DONE, RESULT);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle RV32M multiply/divide unit; define FAST_MUL_EN for a single registered multiply
module mul_div_unit #(parameter int XLEN = 32) (
  input logic CLK,
  input logic RESET,
  mul_div_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ITER, FIX, DONE, MULP} state_t;
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [2:0]        idx;
  logic              m_op, sa, sb, div_zero, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res, hi, lo, r;
  logic [XLEN:0]     sum, t;
  logic              ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, fixed;
`ifdef FAST_MUL_EN
  logic [2*XLEN+1:0] fp;
`endif
  // op index 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; DIV/DIVU read the low half (quotient)
  function automatic logic [XLEN-1:0] sel(input logic [2:0] op, input logic [2*XLEN-1:0] f);
    return (op[2] ? op[1] : op[1:0] != 2'd0) ? f[2*XLEN-1:XLEN] : f[XLEN-1:0];
  endfunction
  // request decode, sign capture and the iterative datapath step for each state
  always_comb begin
    idx      = bus.ALUOP[2:0] - 3'd3;
    m_op     = bus.ALUOP >= 5'd11 && bus.ALUOP <= 5'd18;
    sa       = (idx inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) & bus.OPERAND1[XLEN-1];
    sb       = (idx inside {3'd0, 3'd1, 3'd4, 3'd6}) & bus.OPERAND2[XLEN-1];
    mag_a    = sa ? -bus.OPERAND1 : bus.OPERAND1;
    mag_b    = sb ? -bus.OPERAND2 : bus.OPERAND2;
    div_zero = idx[2] && bus.OPERAND2 == '0;
    ovf      = (idx inside {3'd4, 3'd6}) && bus.OPERAND1 == {1'b1, {(XLEN-1){1'b0}}} && &bus.OPERAND2;
    spec_res = div_zero ? (idx[1] ? bus.OPERAND1 : '1) : (idx[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    hi       = acc_q[2*XLEN-1:XLEN];
    lo       = acc_q[XLEN-1:0];
    sum      = {1'b0, hi} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt  = {sum, lo[XLEN-1:1]};
    t        = {hi, lo[XLEN-1]};
    ge       = t >= {1'b0, b_q};
    r        = ge ? t[XLEN-1:0] - b_q : t[XLEN-1:0];
    div_nxt  = {r, lo[XLEN-2:0], ge};
    fixed    = op_q[2] ? {sa_q ? -hi : hi, (sa_q ^ sb_q) ? -lo : lo} : ((sa_q ^ sb_q) ? -acc_q : acc_q);
`ifdef FAST_MUL_EN
    fp       = $signed({sa_q, hi}) * $signed({sb_q, lo});
`endif
  end
  // next-state and register loads; FLUSH wins over everything, including a START in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    if (bus.FLUSH) state_d = IDLE;
    else case (state_q)
      IDLE: if (bus.START && m_op) begin
        op_d  = idx;
        sa_d  = sa;
        sb_d  = sb;
        b_d   = mag_b;
        acc_d = {{XLEN{1'b0}}, mag_a};
        cnt_d = '0;
        if (div_zero || ovf) begin
          state_d = DONE;
          res_d   = spec_res;
        end
`ifdef FAST_MUL_EN
        else if (!idx[2]) begin
          state_d = MULP;
          acc_d   = {bus.OPERAND1, bus.OPERAND2};
        end
`endif
        else state_d = ITER;
      end
      ITER: begin
        acc_d   = op_q[2] ? div_nxt : mul_nxt;
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? FIX : ITER;
      end
      FIX: begin
        state_d = DONE;
        res_d   = sel(op_q, fixed);
      end
`ifdef FAST_MUL_EN
      MULP: begin
        state_d = DONE;
        res_d   = sel(op_q, fp[2*XLEN-1:0]);
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so an in-flight op is simply dropped
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end
  assign bus.BUSY   = state_q inside {ITER, FIX, MULP};
  assign bus.DONE   = state_q == DONE;
  assign bus.RESULT = res_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results and latencies
module tb_mul_div_unit;
  logic CLK, RESET;
  int n_checks = 0;
  int n_errors = 0;
`ifdef FAST_MUL_EN
  localparam int MD = 2, MB = 1;
`else
  localparam int MD = 34, MB = 33;
`endif
  mul_div_unit_if #(.XLEN(32)) bus ();
  mul_div_unit #(.XLEN(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int flush_at, input int poke_at, input int exp_done, input int exp_busy,
                     input logic [31:0] exp_res);
    int done_at, dones, busy;
    logic [31:0] res_done;
    done_at = 0;
    dones = 0;
    busy = 0;
    res_done = '0;
    @(negedge CLK);
    bus.ALUOP = op;
    bus.OPERAND1 = a;
    bus.OPERAND2 = b;
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    bus.ALUOP = 5'b01011;
    bus.OPERAND1 = $urandom;
    bus.OPERAND2 = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (bus.DONE && done_at == 0) begin
        done_at = k;
        res_done = bus.RESULT;
      end
      dones += int'(bus.DONE);
      busy += int'(bus.BUSY);
      bus.FLUSH = k == flush_at;
      bus.START = k == poke_at;
    end
    bus.FLUSH = 1'b0;
    bus.START = 1'b0;
    check({tag, ".done_at"}, done_at, exp_done);
    check({tag, ".dones"}, dones, exp_done != 0 ? 1 : 0);
    check({tag, ".busy"}, busy, exp_busy);
    check({tag, ".result"}, bus.RESULT, exp_res);
    if (exp_done != 0) check({tag, ".res_at_done"}, res_done, exp_res);
  endtask
  initial begin
    RESET = 1'b1;
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    bus.ALUOP = '0;
    bus.OPERAND1 = '0;
    bus.OPERAND2 = '0;
    repeat (2) @(negedge CLK);
    check("rst.busy", bus.BUSY, 0);
    check("rst.done", bus.DONE, 0);
    check("rst.result", bus.RESULT, 0);
    RESET = 1'b0;
    run("mul",    5'b01011, 32'd7,        32'hFFFFFFFD, 0, 0, MD, MB, 32'hFFFFFFEB);
    run("mulh",   5'b01100, 32'h80000000, 32'h80000000, 0, 0, MD, MB, 32'h40000000);
    run("mulhsu", 5'b01101, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, MD, MB, 32'hFFFFFFFF);
    run("mulhu",  5'b01110, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, MD, MB, 32'hFFFFFFFE);
    run("div",    5'b01111, 32'hFFFFFFF9, 32'd2,        0, 0, 34, 33, 32'hFFFFFFFD);
    run("rem",    5'b10001, 32'hFFFFFFF9, 32'd2,        0, 0, 34, 33, 32'hFFFFFFFF);
    run("divu",   5'b10000, 32'd100,      32'd7,        0, 5, 34, 33, 32'd14);
    run("remu",   5'b10010, 32'd100,      32'd7,        0, 0, 34, 33, 32'd2);
    run("flush",  5'b01111, 32'd1000,     32'd3,        10, 0, 0, 10, 32'd2);
    run("divu93", 5'b10000, 32'd9,        32'd3,        0, 0, 34, 33, 32'd3);
    run("nonm",   5'b00001, 32'd5,        32'd6,        0, 0, 0, 0, 32'd3);
    run("divu0",  5'b10000, 32'h1234,     32'd0,        0, 0, 1, 0, 32'hFFFFFFFF);
    run("rem0",   5'b10001, 32'h1234,     32'd0,        0, 0, 1, 0, 32'h1234);
    run("divovf", 5'b01111, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h80000000);
    run("removf", 5'b10001, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0, 32'd0);
    run("div_b",  5'b01111, 32'd21,       32'hFFFFFFF9, 0, 0, 34, 33, 32'hFFFFFFFD);
    @(negedge CLK);
    bus.ALUOP = 5'b10000;
    bus.OPERAND1 = 32'd50;
    bus.OPERAND2 = 32'd5;
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (6) @(negedge CLK);
    check("mid.busy", bus.BUSY, 1);
    #2;
    RESET = 1'b1;
    #1;
    check("arst.busy", bus.BUSY, 0);
    check("arst.done", bus.DONE, 0);
    check("arst.result", bus.RESULT, 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      check("arst.nodone", bus.DONE, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
